// File: rtl/map_table_ckpt.sv
// -----------------------------------------------------------------------------
// map_table_ckpt
//   Multi-way register rename map table with per-entry ready bits and branch
//   checkpoints. Each cycle it renames up to WAYS instructions, returns source
//   tags/ready bits and the previous destination mapping (old_tag), absorbs
//   CDB_WIDTH completion broadcasts, snapshots the whole map on branch dispatch
//   and restores a snapshot in one cycle on mispredict.
//
// Ports
//   clock, reset                 clock; asynchronous active-low reset
//   src1_idx, src2_idx           per-way source arch regs (WAYS*AW)
//   rn_valid, rn_dst_idx,        per-way rename enable, destination arch reg
//   rn_new_tag                   and new physical tag from the free list
//   src1_tag, src2_tag,          per-way source tags and ready bits
//   src1_ready, src2_ready       (combinational, intra-group bypass applied)
//   old_tag                      previous mapping of rn_dst_idx (for the ROB)
//   cdb_valid, cdb_tag           completion broadcasts
//   ckpt_req, ckpt_id, ckpt_full take snapshot / slot written (tail) / all busy
//   ckpt_release                 free oldest snapshot (branch resolved correct)
//   restore_valid, restore_id    mispredict recovery target slot
//
// Configuration
//   MAP_CDB_BYPASS_EN  when defined, source ready bits are also set by a
//                      same-cycle matching CDB broadcast.
//
// CKPT_DEPTH must be a power of two (pointers wrap by natural overflow).
// -----------------------------------------------------------------------------
module map_table_ckpt #(
  parameter int ARCH_REGS  = 32,
  parameter int PHYS_REGS  = 64,
  parameter int WAYS       = 2,
  parameter int CDB_WIDTH  = 2,
  parameter int CKPT_DEPTH = 4,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int TW = $clog2(PHYS_REGS),
  localparam int CW = $clog2(CKPT_DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WAYS*AW-1:0]        src1_idx,
  input  logic [WAYS*AW-1:0]        src2_idx,
  input  logic [WAYS-1:0]           rn_valid,
  input  logic [WAYS*AW-1:0]        rn_dst_idx,
  input  logic [WAYS*TW-1:0]        rn_new_tag,
  output logic [WAYS*TW-1:0]        src1_tag,
  output logic [WAYS*TW-1:0]        src2_tag,
  output logic [WAYS-1:0]           src1_ready,
  output logic [WAYS-1:0]           src2_ready,
  output logic [WAYS*TW-1:0]        old_tag,
  input  logic [CDB_WIDTH-1:0]      cdb_valid,
  input  logic [CDB_WIDTH*TW-1:0]   cdb_tag,
  input  logic                      ckpt_req,
  output logic [CW-1:0]             ckpt_id,
  output logic                      ckpt_full,
  input  logic                      ckpt_release,
  input  logic                      restore_valid,
  input  logic [CW-1:0]             restore_id
);

`ifdef MAP_CDB_BYPASS_EN
  localparam bit CDB_BYPASS = 1'b1;
`else
  localparam bit CDB_BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [TW-1:0] tag;
    logic          rdy;
  } entry_t;

  entry_t map_q  [ARCH_REGS];
  entry_t map_d  [ARCH_REGS];
  entry_t snap_q [CKPT_DEPTH][ARCH_REGS];
  entry_t snap_d [CKPT_DEPTH][ARCH_REGS];

  logic [CW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW:0]   count_q, count_d;
  logic          alloc, rel_ok;

  function automatic logic cdb_hit(input logic [TW-1:0]           tag,
                                   input logic [CDB_WIDTH-1:0]    cv,
                                   input logic [CDB_WIDTH*TW-1:0] ct);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++)
      if (cv[c] && ct[c*TW +: TW] == tag) hit = 1'b1;
    return hit;
  endfunction

  // Source lookup for one way: arch reg 0 is pinned to {0,1}; an older way in
  // the same group renaming the same register forwards its new tag (not ready).
  function automatic entry_t src_lookup(input logic [AW-1:0]           idx,
                                        input int                      way,
                                        input entry_t                  mapped,
                                        input logic [WAYS-1:0]         v,
                                        input logic [WAYS*AW-1:0]      dst,
                                        input logic [WAYS*TW-1:0]      nt,
                                        input logic [CDB_WIDTH-1:0]    cv,
                                        input logic [CDB_WIDTH*TW-1:0] ct);
    entry_t e;
    logic   fwd;
    e   = (idx == '0) ? '{tag: '0, rdy: 1'b1} : mapped;
    fwd = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (k < way && v[k] && dst[k*AW +: AW] != '0 && dst[k*AW +: AW] == idx) begin
        e   = '{tag: nt[k*TW +: TW], rdy: 1'b0};
        fwd = 1'b1;
      end
    end
    // A same-group rename hides the broadcast: the forwarded tag is brand new.
    if (CDB_BYPASS && !fwd && cdb_hit(e.tag, cv, ct)) e.rdy = 1'b1;
    return e;
  endfunction

  // Combinational lookup path
  always_comb begin
    entry_t        e1, e2;
    logic [AW-1:0] d;
    logic [TW-1:0] ot;
    // NOTE: every output gets a default before the loops so no path can
    // leave a bit unassigned and infer a latch.
    src1_tag   = '0;
    src2_tag   = '0;
    src1_ready = '0;
    src2_ready = '0;
    old_tag    = '0;
    for (int j = 0; j < WAYS; j++) begin
      e1 = src_lookup(src1_idx[j*AW +: AW], j, map_q[src1_idx[j*AW +: AW]],
                      rn_valid, rn_dst_idx, rn_new_tag, cdb_valid, cdb_tag);
      e2 = src_lookup(src2_idx[j*AW +: AW], j, map_q[src2_idx[j*AW +: AW]],
                      rn_valid, rn_dst_idx, rn_new_tag, cdb_valid, cdb_tag);
      src1_tag[j*TW +: TW] = e1.tag;
      src1_ready[j]        = e1.rdy;
      src2_tag[j*TW +: TW] = e2.tag;
      src2_ready[j]        = e2.rdy;

      d  = rn_dst_idx[j*AW +: AW];
      ot = (d == '0) ? '0 : map_q[d].tag;
      for (int k = 0; k < WAYS; k++)
        if (k < j && rn_valid[k] && d != '0 && rn_dst_idx[k*AW +: AW] == d)
          ot = rn_new_tag[k*TW +: TW];
      old_tag[j*TW +: TW] = ot;
    end
  end

  assign ckpt_id   = tail_q;
  assign ckpt_full = (count_q == (CW+1)'(CKPT_DEPTH));

  // Next-state: CDB first, then renames (higher way overwrites lower), so a
  // same-cycle rename beats a broadcast of the register's old tag.
  always_comb begin
    alloc = ckpt_req && !ckpt_full && !restore_valid;
    // Restoring to the head slot discards every checkpoint, leaving nothing
    // for a simultaneous release to free.
    rel_ok = ckpt_release && (count_q != '0) &&
             !(restore_valid && restore_id == head_q);

    for (int s = 0; s < CKPT_DEPTH; s++) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        snap_d[s][i] = snap_q[s][i];
        if (cdb_hit(snap_q[s][i].tag, cdb_valid, cdb_tag)) snap_d[s][i].rdy = 1'b1;
      end
    end
    for (int i = 0; i < ARCH_REGS; i++) begin
      map_d[i] = map_q[i];
      if (cdb_hit(map_q[i].tag, cdb_valid, cdb_tag)) map_d[i].rdy = 1'b1;
    end

    head_d = head_q + CW'(rel_ok);
    if (restore_valid) begin
      for (int i = 0; i < ARCH_REGS; i++) map_d[i] = snap_d[restore_id][i];
      tail_d  = restore_id;
      count_d = {1'b0, restore_id - head_d};
    end else begin
      for (int k = 0; k < WAYS; k++)
        if (rn_valid[k] && rn_dst_idx[k*AW +: AW] != '0)
          map_d[rn_dst_idx[k*AW +: AW]] = '{tag: rn_new_tag[k*TW +: TW], rdy: 1'b0};
      if (alloc)
        for (int i = 0; i < ARCH_REGS; i++) snap_d[tail_q][i] = map_d[i];
      tail_d  = tail_q + CW'(alloc);
      count_d = count_q + (CW+1)'(alloc) - (CW+1)'(rel_ok);
    end
  end

  // NOTE: the snapshot array is reset along with the map so a stray restore
  // after reset recovers the identity mapping rather than unknown tags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= '{tag: TW'(i), rdy: 1'b1};
      for (int s = 0; s < CKPT_DEPTH; s++)
        for (int i = 0; i < ARCH_REGS; i++) snap_q[s][i] <= '{tag: TW'(i), rdy: 1'b1};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      map_q   <= map_d;
      snap_q  <= snap_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_map_table_ckpt.sv
// -----------------------------------------------------------------------------
// tb_map_table_ckpt
//   Self-checking bench for map_table_ckpt. Expected output values are queued
//   as stimulus is driven and popped/compared at the following falling edge.
// -----------------------------------------------------------------------------
module tb_map_table_ckpt;
  localparam int ARCH_REGS  = 32;
  localparam int PHYS_REGS  = 64;
  localparam int WAYS       = 2;
  localparam int CDB_WIDTH  = 2;
  localparam int CKPT_DEPTH = 4;
  localparam int AW = 5;
  localparam int TW = 6;
  localparam int CW = 2;

`ifdef MAP_CDB_BYPASS_EN
  localparam logic [31:0] BYP = 32'd1;
`else
  localparam logic [31:0] BYP = 32'd0;
`endif

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [WAYS*AW-1:0]      src1_idx, src2_idx, rn_dst_idx;
  logic [WAYS-1:0]         rn_valid;
  logic [WAYS*TW-1:0]      rn_new_tag;
  logic [WAYS*TW-1:0]      src1_tag, src2_tag, old_tag;
  logic [WAYS-1:0]         src1_ready, src2_ready;
  logic [CDB_WIDTH-1:0]    cdb_valid;
  logic [CDB_WIDTH*TW-1:0] cdb_tag;
  logic                    ckpt_req, ckpt_full, ckpt_release, restore_valid;
  logic [CW-1:0]           ckpt_id, restore_id;

  map_table_ckpt #(
    .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .WAYS(WAYS),
    .CDB_WIDTH(CDB_WIDTH), .CKPT_DEPTH(CKPT_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .src1_idx(src1_idx), .src2_idx(src2_idx),
    .rn_valid(rn_valid), .rn_dst_idx(rn_dst_idx), .rn_new_tag(rn_new_tag),
    .src1_tag(src1_tag), .src2_tag(src2_tag),
    .src1_ready(src1_ready), .src2_ready(src2_ready),
    .old_tag(old_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .ckpt_req(ckpt_req), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_release(ckpt_release),
    .restore_valid(restore_valid), .restore_id(restore_id)
  );

  initial forever #5 clock = ~clock;

  typedef enum int {
    S1_TAG0, S1_RDY0, S2_TAG0, S2_RDY0,
    S1_TAG1, S1_RDY1, S2_TAG1, S2_RDY1,
    OLD0, OLD1, CID, CFULL
  } sel_e;

  typedef struct {
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      S1_TAG0: return 32'(src1_tag[0 +: TW]);
      S1_RDY0: return 32'(src1_ready[0]);
      S2_TAG0: return 32'(src2_tag[0 +: TW]);
      S2_RDY0: return 32'(src2_ready[0]);
      S1_TAG1: return 32'(src1_tag[TW +: TW]);
      S1_RDY1: return 32'(src1_ready[1]);
      S2_TAG1: return 32'(src2_tag[TW +: TW]);
      S2_RDY1: return 32'(src2_ready[1]);
      OLD0:    return 32'(old_tag[0 +: TW]);
      OLD1:    return 32'(old_tag[TW +: TW]);
      CID:     return 32'(ckpt_id);
      default: return 32'(ckpt_full);
    endcase
  endfunction

  task automatic expect_out(input sel_e s, input logic [31:0] v);
    exp_t e;
    e.sel = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clock);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.sel.name(), observe(e.sel), e.val);
    end
  endtask

  task automatic idle();
    src1_idx      = '0;
    src2_idx      = '0;
    rn_valid      = '0;
    rn_dst_idx    = '0;
    rn_new_tag    = '0;
    cdb_valid     = '0;
    cdb_tag       = '0;
    ckpt_req      = 1'b0;
    ckpt_release  = 1'b0;
    restore_valid = 1'b0;
    restore_id    = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic set_src(input int w, input int s1, input int s2);
    src1_idx[w*AW +: AW] = AW'(s1);
    src2_idx[w*AW +: AW] = AW'(s2);
  endtask

  task automatic set_rn(input int w, input int dst, input int tag);
    rn_valid[w]            = 1'b1;
    rn_dst_idx[w*AW +: AW] = AW'(dst);
    rn_new_tag[w*TW +: TW] = TW'(tag);
  endtask

  task automatic set_cdb(input int l, input int tag);
    cdb_valid[l]         = 1'b1;
    cdb_tag[l*TW +: TW]  = TW'(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    // Reset held: identity mapping, no checkpoints.
    reset = 1'b0;
    set_src(0, 5, 0);
    expect_out(S1_TAG0, 5);  expect_out(S1_RDY0, 1);
    expect_out(S2_TAG0, 0);  expect_out(S2_RDY0, 1);
    expect_out(CFULL, 0);    expect_out(CID, 0);
    settle();
    tick();
    reset = 1'b1;
    set_src(0, 5, 6);
    expect_out(S1_TAG0, 5);  expect_out(S1_RDY0, 1);
    expect_out(S2_TAG0, 6);  expect_out(S2_RDY0, 1);
    settle();
    tick();

    // Intra-group bypass: way0 r3->40, way1 reads r3 and renames r3->41.
    set_rn(0, 3, 40);
    set_src(1, 3, 0);
    set_rn(1, 3, 41);
    expect_out(S1_TAG1, 40); expect_out(S1_RDY1, 0);
    expect_out(OLD1, 40);    expect_out(OLD0, 3);
    expect_out(S2_TAG1, 0);  expect_out(S2_RDY1, 1);
    settle();
    tick();
    set_src(0, 3, 3);
    expect_out(S1_TAG0, 41); expect_out(S1_RDY0, 0);
    settle();
    tick();

    // Same destination in both ways: highest way wins.
    set_rn(0, 10, 20);
    set_rn(1, 10, 21);
    set_src(1, 10, 0);
    expect_out(S1_TAG1, 20); expect_out(S1_RDY1, 0);
    expect_out(OLD1, 20);    expect_out(OLD0, 10);
    settle();
    tick();
    // Renames of r0 are ignored and do not bypass.
    set_rn(0, 0, 54);
    set_rn(1, 0, 55);
    set_src(1, 0, 10);
    set_src(0, 10, 0);
    expect_out(S1_TAG1, 0);  expect_out(S1_RDY1, 1);
    expect_out(S2_TAG1, 21); expect_out(S2_RDY1, 0);
    expect_out(OLD1, 0);     expect_out(OLD0, 0);
    expect_out(S1_TAG0, 21);
    settle();
    tick();
    set_src(0, 0, 10);
    expect_out(S1_TAG0, 0);  expect_out(S1_RDY0, 1);
    expect_out(S2_TAG0, 21); expect_out(S2_RDY0, 0);
    settle();
    tick();

    // CDB wakeup; rename bypass beats CDB; same-cycle rename beats CDB.
    set_rn(0, 7, 50);
    tick();
    set_cdb(0, 50);
    set_src(0, 7, 0);
    set_rn(0, 11, 47);
    set_cdb(1, 47);
    set_src(1, 11, 0);
    expect_out(S1_TAG0, 50); expect_out(S1_RDY0, BYP);
    expect_out(S1_TAG1, 47); expect_out(S1_RDY1, 0);
    settle();
    tick();
    set_src(0, 7, 11);
    expect_out(S1_TAG0, 50); expect_out(S1_RDY0, 1);
    expect_out(S2_TAG0, 47); expect_out(S2_RDY0, 0);
    settle();
    tick();

    // Checkpoint, later rename, CDB into snapshot, restore.
    set_rn(0, 4, 33);
    ckpt_req = 1'b1;
    expect_out(CID, 0);
    settle();
    tick();
    set_rn(0, 4, 34);
    expect_out(CID, 1);
    settle();
    tick();
    set_src(0, 4, 0);
    set_cdb(0, 33);
    expect_out(S1_TAG0, 34); expect_out(S1_RDY0, 0);
    settle();
    tick();
    restore_valid = 1'b1;
    restore_id    = 2'd0;
    tick();
    set_src(0, 4, 3);
    expect_out(S1_TAG0, 33); expect_out(S1_RDY0, 1);
    expect_out(S2_TAG0, 41); expect_out(S2_RDY0, 0);
    expect_out(CID, 0);      expect_out(CFULL, 0);
    settle();
    tick();

    // Fill all slots, drop a request when full, release, wrap the tail.
    for (int i = 0; i < CKPT_DEPTH; i++) begin
      ckpt_req = 1'b1;
      expect_out(CID, 32'(i));
      expect_out(CFULL, 0);
      settle();
      tick();
    end
    ckpt_req = 1'b1;
    expect_out(CFULL, 1);    expect_out(CID, 0);
    settle();
    tick();
    ckpt_release = 1'b1;
    expect_out(CFULL, 1);    expect_out(CID, 0);
    settle();
    tick();
    ckpt_req = 1'b1;
    expect_out(CFULL, 0);    expect_out(CID, 0);
    settle();
    tick();
    expect_out(CFULL, 1);    expect_out(CID, 1);
    settle();
    tick();

    // Restore overrides ckpt_req and renames; same-cycle CDB lands.
    restore_valid = 1'b1;
    restore_id    = 2'd2;
    ckpt_req      = 1'b1;
    set_rn(0, 9, 60);
    set_cdb(1, 41);
    expect_out(CID, 1);
    settle();
    tick();
    set_src(0, 9, 3);
    expect_out(S1_TAG0, 9);  expect_out(S1_RDY0, 1);
    expect_out(S2_TAG0, 41); expect_out(S2_RDY0, 1);
    expect_out(CID, 2);      expect_out(CFULL, 0);
    settle();
    tick();
    ckpt_release = 1'b1;
    tick();
    ckpt_req = 1'b1;
    expect_out(CID, 2);
    settle();
    tick();
    expect_out(CID, 3);      expect_out(CFULL, 0);
    settle();

    // Asynchronous reset mid-operation.
    tick();
    #2;
    reset = 1'b0;
    set_src(0, 3, 9);
    expect_out(S1_TAG0, 3);  expect_out(S1_RDY0, 1);
    expect_out(S2_TAG0, 9);  expect_out(S2_RDY0, 1);
    expect_out(CID, 0);      expect_out(CFULL, 0);
    settle();
    tick();
    reset = 1'b1;
    set_src(0, 4, 7);
    expect_out(S1_TAG0, 4);  expect_out(S1_RDY0, 1);
    expect_out(S2_TAG0, 7);  expect_out(S2_RDY0, 1);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_table_ckpt.md
# map_table_ckpt

Parametrised, multi-way register rename map table with per-entry ready bits and branch checkpoints, the next-generation replacement for the single-way `map_table` in the R10K rename stage. Each cycle it renames up to `WAYS` instructions, returns source tags, source ready bits and the old destination tag for the ROB, and absorbs CDB completion broadcasts. It snapshots the full map on branch dispatch and restores a snapshot in one cycle on mispredict.

## Interface
- `ARCH_REGS`, 32, architectural registers; index width `AW = $clog2(ARCH_REGS)`.
- `PHYS_REGS`, 64, physical registers; tag width `TW = $clog2(PHYS_REGS)`.
- `WAYS`, 2, rename/lookup ways per cycle.
- `CDB_WIDTH`, 2, completion broadcasts per cycle.
- `CKPT_DEPTH`, 4, snapshot slots; id width `CW = $clog2(CKPT_DEPTH)`.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `src1_idx`, `src2_idx`  in  WAYS*AW  per-way source arch regs.
- `rn_valid`  in  WAYS  per-way rename enable.
- `rn_dst_idx`  in  WAYS*AW  per-way destination arch reg.
- `rn_new_tag`  in  WAYS*TW  per-way new physical tag from free list.
- `src1_tag`, `src2_tag`  out  WAYS*TW  source tags.
- `src1_ready`, `src2_ready`  out  WAYS  source ready bits.
- `old_tag`  out  WAYS*TW  previous mapping of `rn_dst_idx` (T_old to ROB).
- `cdb_valid`  in  CDB_WIDTH; `cdb_tag`  in  CDB_WIDTH*TW  completed tags.
- `ckpt_req`  in  1  take snapshot this cycle.
- `ckpt_id`  out  CW  slot the snapshot is written to (tail).
- `ckpt_full`  out  1  all slots occupied.
- `ckpt_release`  in  1  free oldest slot (branch resolved correct).
- `restore_valid`  in  1; `restore_id`  in  CW  mispredict recovery target.

## Operation
- Map entry = {tag, ready}. Reset: entry i = {i, 1}; checkpoint head = tail = count = 0.
- Arch reg 0 hardwired: lookup returns {0,1}; renames with `rn_dst_idx`=0 ignored; `old_tag`=0.
- Lookup combinational from current map plus intra-group bypass: way j sources/`old_tag` see the `rn_new_tag` (ready=0) of the highest valid way k<j with matching dst.
- Write: map[dst] <= {new_tag, 0}; same dst in several ways, highest way wins.
- CDB: every entry (map and all valid snapshots) whose tag matches a valid `cdb_tag` sets ready=1. Same-cycle rename to that arch reg wins (ready=0).
- Checkpoint: `ckpt_req` && !`ckpt_full` writes snapshot of the next-cycle map (including this cycle's renames and CDB) into slot tail; tail++, count++. `ckpt_req` when full is dropped; no state change. Branch must be the highest valid way of its group.
- Release: `ckpt_release` with count>0 frees head; head++, count--. With count=0, ignored.
- Restore: map <= snapshot[`restore_id`] with same-cycle CDB applied; tail <= `restore_id` (that slot and younger discarded); count recomputed as (restore_id - head) mod CKPT_DEPTH. Restore overrides renames and `ckpt_req` that cycle; a simultaneous `ckpt_release` is still applied to head.
- Head/tail pointers wrap modulo CKPT_DEPTH; count is CW+1 bits.

## Timing
- Lookups, `old_tag`, `ckpt_id`, `ckpt_full`: zero latency, combinational.
- Renames, CDB, checkpoint, release, restore: visible to lookups in the cycle after the edge.
- Reset asserted mid-operation clears all state immediately, regardless of clock; outputs show reset mapping while held.
- `ckpt_full` = (count == CKPT_DEPTH); reset value 0. `ckpt_id` reset value 0.

## Configuration
- `MAP_CDB_BYPASS_EN` defined: `src*_ready` also set combinationally when the source tag matches a same-cycle valid `cdb_tag` (rename bypass still takes precedence).
- Undefined: ready bits come only from registered state; a broadcast is visible one cycle later.

## Test plan
- Reset low then high -> `src1_idx`=5 gives tag 5 ready 1; `ckpt_full`=0, `ckpt_id`=0.
- Way0 renames r3->40, way1 reads r3 and renames r3->41 same cycle -> way1 `src1_tag`=40 ready 0, `old_tag`=40; next cycle r3 reads {41,0}.
- r7->50 renamed; next cycle `cdb_tag`=50 -> r7 ready next cycle (same cycle with `MAP_CDB_BYPASS_EN`).
- r4->33 then `ckpt_req` (id 0), then r4->34; CDB 33 broadcast; restore id 0 -> r4 reads {33,1}, `ckpt_id`=0.
- Four `ckpt_req` -> `ckpt_full`=1; fifth dropped; `ckpt_release` -> full 0, next `ckpt_id` wraps to 0.
- Restore and `ckpt_req` same cycle -> restore applied, no new slot allocated.
